// File: rtl/instr_enc_pkg.sv
// Shared types, field positions, error codes and encode/check helpers for instr_word_encoder.
// Build option: INSTR_ENC_ERR_HALT_EN adds the HALT state entered after a rejected field set.
package instr_enc_pkg;

  typedef enum logic [1:0] {
    TIPO_ARITH = 2'b00,
    TIPO_XFER  = 2'b01,
    TIPO_CTRL  = 2'b10,
    TIPO_BAD   = 2'b11
  } tipo_e;

  typedef enum logic [1:0] {
    OP_MOV      = 2'b00,
    OP_LDR      = 2'b01,
    OP_STR      = 2'b10,
    OP_XFER_BAD = 2'b11
  } xfer_op_e;

  typedef enum logic [1:0] {
    OP_B   = 2'b00,
    OP_BL  = 2'b01,
    OP_CMP = 2'b10,
    OP_BEQ = 2'b11
  } ctrl_op_e;

  localparam int TIPO_LSB = 30;
  localparam int OP_LSB   = 28;
  localparam int INM_BIT  = 27;
  localparam int RD_LSB   = 23;
  localparam int RN_LSB   = 19;
  localparam int RM_LSB   = 15;
  localparam int IMM19_W  = 19;
  localparam int BR_W     = 27;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_TIPO = 2'd1;
  localparam logic [1:0] ERR_OP   = 2'd2;
  localparam logic [1:0] ERR_IMM  = 2'd3;

`ifdef INSTR_ENC_ERR_HALT_EN
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;
`else
  typedef enum logic {ST_RUN = 1'b0} state_e;
`endif

  // Immediates must fit in 19 signed bits: bits 26:19 replicate bit 18.
  function automatic logic [1:0] checkFields(input logic [1:0] tipo, input logic [1:0] op,
                                             input logic inm, input logic [26:0] imm);
    logic [1:0] code;
    code = ERR_NONE;
    if (tipo == TIPO_BAD)
      code = ERR_TIPO;
    else if (tipo == TIPO_XFER && op == OP_XFER_BAD)
      code = ERR_OP;
    else if (inm && tipo != TIPO_CTRL && imm[26:19] != {8{imm[18]}})
      code = ERR_IMM;
    return code;
  endfunction

  function automatic logic [31:0] encodeWord(input logic [1:0] tipo, input logic [1:0] op,
                                             input logic inm, input logic [3:0] rd,
                                             input logic [3:0] rn, input logic [3:0] rm,
                                             input logic [26:0] imm);
    logic [31:0] w;
    w = '0;
    w[TIPO_LSB +: 2] = tipo;
    w[OP_LSB +: 2]   = op;
    if (tipo == TIPO_CTRL) begin
      // Control flow never carries the Inm bit; CMP is register-only.
      if (op == OP_CMP) begin
        w[RN_LSB +: 4] = rn;
        w[RM_LSB +: 4] = rm;
      end else begin
        w[BR_W-1:0] = imm;
      end
    end else begin
      w[INM_BIT]     = inm;
      w[RD_LSB +: 4] = rd;
      if (!(tipo == TIPO_XFER && op == OP_MOV))
        w[RN_LSB +: 4] = rn;
      if (inm)
        w[IMM19_W-1:0] = imm[IMM19_W-1:0];
      else
        w[RM_LSB +: 4] = rm;
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with full/empty flags and a synchronous clear.
// Read data is forced to zero while empty so the word output is clean after reset.
module instr_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wrPtr;
  logic [PTR_W:0]   r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = i_push && !o_full && !i_clear;
  assign w_doPop  = i_pop && !o_empty && !i_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush)
        r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
      if (w_doPop)
        r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush)
      r_mem[r_wrPtr[PTR_W-1:0]] <= i_wdata;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                   (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign o_rdata = o_empty ? '0 : r_mem[r_rdPtr[PTR_W-1:0]];

endmodule

// File: rtl/instr_word_encoder.sv
// Encodes instruction field sets into 32-bit words and streams them with sequential addresses.
// Build option: INSTR_ENC_ERR_HALT_EN makes a rejection halt input acceptance until clear.
module instr_word_encoder
  import instr_enc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_tipo,
  input  logic [1:0]        i_op,
  input  logic              i_inm,
  input  logic [3:0]        i_rd,
  input  logic [3:0]        i_rn,
  input  logic [3:0]        i_rm,
  input  logic [26:0]       i_imm,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_word,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_err_pulse,
  output logic [1:0]        o_err_code
);

  state_e            r_state;
  state_e            w_stateNext;
  logic [1:0]        w_fieldErr;
  logic [31:0]       w_word;
  logic              w_inFire;
  logic              w_reject;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] r_addr;
  logic              r_errPulse;
  logic [1:0]        r_errCode;

  assign w_fieldErr = checkFields(i_tipo, i_op, i_inm, i_imm);
  assign w_word     = encodeWord(i_tipo, i_op, i_inm, i_rd, i_rn, i_rm, i_imm);
  assign w_inFire   = i_in_valid && o_in_ready;
  assign w_reject   = w_inFire && (w_fieldErr != ERR_NONE);
  assign w_push     = w_inFire && (w_fieldErr == ERR_NONE) && !i_clear;
  assign w_pop      = o_out_valid && i_out_ready && !i_clear;

  instr_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (i_clear),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_rdata (o_out_word),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_out_valid = !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_RUN;
    else
      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (i_clear)
      w_stateNext = ST_RUN;
`ifdef INSTR_ENC_ERR_HALT_EN
    else if (w_reject)
      w_stateNext = ST_HALT;
`endif
  end

  // Gating on rst keeps the input side closed while reset is held.
  always_comb begin
    o_in_ready = !rst && !w_full && (r_state == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_addr <= '0;
    else if (i_clear)
      r_addr <= '0;
    else if (w_pop)
      r_addr <= r_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errPulse <= 1'b0;
      r_errCode  <= ERR_NONE;
    end else if (i_clear) begin
      r_errPulse <= 1'b0;
      r_errCode  <= ERR_NONE;
    end else begin
      r_errPulse <= w_reject;
      if (w_reject)
        r_errCode <= w_fieldErr;
    end
  end

  assign o_out_addr  = r_addr;
  assign o_err_pulse = r_errPulse;
  assign o_err_code  = r_errCode;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: vector table plus fill, clear and reset sequences.
// Expectations for rejections follow INSTR_ENC_ERR_HALT_EN when it is defined.
module tb_instr_word_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  typedef struct {
    logic [1:0]  tipo;
    logic [1:0]  op;
    logic        inm;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [26:0] imm;
    logic [1:0]  errCode;
    logic [31:0] word;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              inValid;
  logic              inReady;
  logic [1:0]        tipo;
  logic [1:0]        op;
  logic              inm;
  logic [3:0]        rd;
  logic [3:0]        rn;
  logic [3:0]        rm;
  logic [26:0]       imm;
  logic              outValid;
  logic              outReady;
  logic [31:0]       outWord;
  logic [ADDR_W-1:0] outAddr;
  logic              errPulse;
  logic [1:0]        errCode;

  vec_t              vecs [14];
  logic [31:0]       expQ [$];
  logic [31:0]       expWord;
  logic [ADDR_W-1:0] expAddr;
  int                compared;
  int                mismatched;
  logic              expReadyAfterErr;

  instr_word_encoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (clear),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_tipo      (tipo),
    .i_op        (op),
    .i_inm       (inm),
    .i_rd        (rd),
    .i_rn        (rn),
    .i_rm        (rm),
    .i_imm       (imm),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_word  (outWord),
    .o_out_addr  (outAddr),
    .o_err_pulse (errPulse),
    .o_err_code  (errCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Output side: any handshake seen at the falling edge must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !clear && outValid && outReady) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected word: got 0x%08h with nothing queued", outWord);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("out_word", outWord, expWord);
        checkOutput("out_addr", 32'(outAddr), 32'(expAddr));
        expAddr = expAddr + ADDR_W'(1);
      end
    end
  end

  task automatic driveFields(input vec_t v);
    tipo = v.tipo;
    op   = v.op;
    inm  = v.inm;
    rd   = v.rd;
    rn   = v.rn;
    rm   = v.rm;
    imm  = v.imm;
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic applyStimulus(input vec_t v);
    bit accepted;
    accepted = 1'b0;
    driveFields(v);
    inValid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inReady) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL in_ready timeout: got 0, expected 1 within 40 cycles");
      inValid = 1'b0;
      return;
    end
    if (v.errCode == 2'd0)
      expQ.push_back(v.word);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40; i++) begin
      if (expQ.size() == 0)
        break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain queue", 32'(expQ.size()), 32'd0);
    checkOutput("drained out_valid", 32'(outValid), 32'd0);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    expQ.delete();
    expAddr = '0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 1'b1, 4'd3,  4'd2, 4'd0, 27'h0000005, 2'd0, 32'h09900005};
    vecs[1]  = '{2'b00, 2'b01, 1'b0, 4'd1,  4'd2, 4'd3, 27'h0000000, 2'd0, 32'h10918000};
    vecs[2]  = '{2'b10, 2'b11, 1'b0, 4'd0,  4'd0, 4'd0, 27'h7FFFFFC, 2'd0, 32'hB7FFFFFC};
    vecs[3]  = '{2'b00, 2'b10, 1'b1, 4'd0,  4'd0, 4'd0, 27'h7FFFFFF, 2'd0, 32'h2807FFFF};
    vecs[4]  = '{2'b01, 2'b00, 1'b1, 4'd5,  4'd9, 4'd0, 27'h0000123, 2'd0, 32'h4A800123};
    vecs[5]  = '{2'b01, 2'b01, 1'b0, 4'd2,  4'd4, 4'd6, 27'h0000000, 2'd0, 32'h51230000};
    vecs[6]  = '{2'b11, 2'b00, 1'b0, 4'd1,  4'd1, 4'd1, 27'h0000000, 2'd1, 32'h00000000};
    vecs[7]  = '{2'b10, 2'b10, 1'b1, 4'd7,  4'd3, 4'd4, 27'h00000FF, 2'd0, 32'hA01A0000};
    vecs[8]  = '{2'b10, 2'b01, 1'b1, 4'hF,  4'd0, 4'd0, 27'h0000010, 2'd0, 32'h90000010};
    vecs[9]  = '{2'b01, 2'b11, 1'b0, 4'd1,  4'd2, 4'd3, 27'h0000000, 2'd2, 32'h00000000};
    vecs[10] = '{2'b00, 2'b11, 1'b1, 4'd0,  4'd1, 4'd0, 27'h7FFFFFD, 2'd0, 32'h380FFFFD};
    vecs[11] = '{2'b00, 2'b00, 1'b1, 4'd3,  4'd2, 4'd0, 27'h0080000, 2'd3, 32'h00000000};
    vecs[12] = '{2'b01, 2'b01, 1'b1, 4'd3,  4'd2, 4'd0, 27'h7F00000, 2'd3, 32'h00000000};
    vecs[13] = '{2'b00, 2'b00, 1'b0, 4'd1,  4'd1, 4'd1, 27'h0080000, 2'd0, 32'h00888000};

`ifdef INSTR_ENC_ERR_HALT_EN
    expReadyAfterErr = 1'b0;
`else
    expReadyAfterErr = 1'b1;
`endif

    compared   = 0;
    mismatched = 0;
    expAddr    = '0;
    rst        = 1'b1;
    clear      = 1'b0;
    inValid    = 1'b0;
    outReady   = 1'b0;
    driveFields(vecs[0]);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", 32'(inReady), 32'd0);
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset out_word", outWord, 32'd0);
    checkOutput("reset out_addr", 32'(outAddr), 32'd0);
    checkOutput("reset err_pulse", 32'(errPulse), 32'd0);
    checkOutput("reset err_code", 32'(errCode), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset in_ready", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;

    // Streaming pass over the whole table; each rejection is followed by a clear.
    outReady = 1'b1;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].errCode != 2'd0) begin
        @(negedge clk);
        checkOutput($sformatf("vec%0d err_pulse", i), 32'(errPulse), 32'd1);
        checkOutput($sformatf("vec%0d err_code", i), 32'(errCode), 32'(vecs[i].errCode));
        @(negedge clk);
        checkOutput($sformatf("vec%0d err_pulse drop", i), 32'(errPulse), 32'd0);
        checkOutput($sformatf("vec%0d err_code held", i), 32'(errCode), 32'(vecs[i].errCode));
        checkOutput($sformatf("vec%0d in_ready after reject", i), 32'(inReady), 32'(expReadyAfterErr));
        @(posedge clk);
        #1;
        waitDrain();
        pulseClear();
        @(negedge clk);
        checkOutput("clear in_ready", 32'(inReady), 32'd1);
        checkOutput("clear out_addr", 32'(outAddr), 32'd0);
        checkOutput("clear err_code", 32'(errCode), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    waitDrain();
    pulseClear();

    // Fill to DEPTH with the consumer stalled, then release.
    outReady = 1'b0;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    applyStimulus(vecs[5]);
    applyStimulus(vecs[13]);
    @(negedge clk);
    checkOutput("full in_ready", 32'(inReady), 32'd0);
    checkOutput("stall out_valid", 32'(outValid), 32'd1);
    checkOutput("stall out_word", outWord, 32'h09900005);
    checkOutput("stall out_addr", 32'(outAddr), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("stall word stable", outWord, 32'h09900005);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("full with pop in_ready", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(vecs[2]);
    waitDrain();
    checkOutput("wrapped next addr", 32'(outAddr), 32'd1);

    // Clear wins over a same-cycle push and pop.
    outReady = 1'b0;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    driveFields(vecs[5]);
    inValid  = 1'b1;
    outReady = 1'b1;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    inValid = 1'b0;
    expQ.delete();
    expAddr = '0;
    @(negedge clk);
    checkOutput("clear-beats out_valid", 32'(outValid), 32'd0);
    checkOutput("clear-beats out_addr", 32'(outAddr), 32'd0);
    checkOutput("clear-beats out_word", outWord, 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-stream with a nonzero address, queued words and a held error code.
    applyStimulus(vecs[0]);
    waitDrain();
    outReady = 1'b0;
    applyStimulus(vecs[1]);
    applyStimulus(vecs[5]);
    applyStimulus(vecs[6]);
    @(negedge clk);
    checkOutput("pre-reset err_code", 32'(errCode), 32'd1);
    checkOutput("pre-reset out_addr", 32'(outAddr), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async reset in_ready", 32'(inReady), 32'd0);
    checkOutput("async reset out_valid", 32'(outValid), 32'd0);
    checkOutput("async reset out_word", outWord, 32'd0);
    checkOutput("async reset out_addr", 32'(outAddr), 32'd0);
    checkOutput("async reset err_pulse", 32'(errPulse), 32'd0);
    checkOutput("async reset err_code", 32'(errCode), 32'd0);
    expQ.delete();
    expAddr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after reset in_ready", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    applyStimulus(vecs[3]);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_word_encoder.md
# instr_word_encoder

Packs instruction fields (type, operation, immediate flag, registers, immediate) into 32-bit instruction words and streams them, with sequential addresses, toward the instruction-memory write port. It is the encode side of the main instruction decoder: every word it emits decodes back to the same type/op/Inm. Words are buffered in a small FIFO so a program loader or test sequencer can push at full rate while memory accepts words under backpressure. Illegal field combinations are rejected and reported.

## Interface
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- ADDR_W, 8, width of emitted instruction address
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous: empties FIFO, zeroes address counter, leaves HALT
- in_valid  in  1  field set presented
- in_ready  out  1  field set accepted when in_valid & in_ready
- in_tipo  in  2  instruction type: 00 arith, 01 data transfer, 10 control flow
- in_op  in  2  operation within type
- in_inm  in  1  immediate operand select
- in_rd / in_rn / in_rm  in  4 each  destination, first source, second source register
- in_imm  in  27  signed immediate / branch offset
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  address for out_word
- err_pulse  out  1  one-cycle pulse on rejected input
- err_code  out  2  cause of last rejection, held until next rejection, clear or reset

## Operation
- Word layout: [31:30] tipo, [29:28] op, [27] Inm, [26:23] Rd, [22:19] Rn, [18:15] Rm when Inm=0 ([14:0]=0), [18:0] imm19 when Inm=1.
- Arithmetic (00, any op): Rd, Rn, Rm or imm19.
- Transfer (01): MOV op00: Rd, Rm/imm19, Rn field 0; LDR op01 / STR op10: Rd, Rn base, Rm/imm19 offset.
- Control flow (10): B 00, BL 01, BEQ 11: [26:0]=in_imm; CMP 10: Rn, Rm, Rd field 0. Inm bit forced to 0 for all tipo 10; register fields ignored for branches.
- Rejections (no FIFO write, err_pulse=1): code 1 tipo=11; code 2 tipo=01 & op=11; code 3 Inm=1 (tipo 00/01) and in_imm[26:19] not all equal to in_imm[18]. Rejected inputs are still handshaken (consumed).
- FSM: RUN (normal), HALT (entered only on rejection with the config macro; in_ready=0). clear or reset → RUN.
- Unused register bits in each format are driven to 0.

## Timing
- Reset: in_ready=0 while rst high, 1 in the first cycle after; out_valid=0, out_word=0, out_addr=0, err_pulse=0, err_code=0, FSM=RUN, FIFO empty.
- Latency: field set accepted at edge N → out_valid=1 with its word from edge N (visible cycle N+1) when FIFO empty.
- in_ready = !full & RUN; no pass-through when full, even if a pop occurs the same cycle.
- Simultaneous push and pop when not full: both occur, occupancy unchanged.
- out_word/out_valid stable while out_valid & !out_ready.
- out_addr = count of words popped since reset/clear; increments on each out handshake, wraps 2^ADDR_W-1 → 0.
- err_pulse asserted in cycle after the rejected handshake edge.
- clear beats a same-cycle push and pop; FIFO contents are discarded.

## Configuration
- INSTR_ENC_ERR_HALT_EN defined: rejection moves FSM to HALT; in_ready=0 until clear; FIFO continues draining.
- Undefined: rejected word dropped, err pulsed, FSM stays in RUN; HALT state absent.

## Structure
- Package instr_enc_pkg: tipo/op enumerations, field bit positions, err code constants, FSM state typedef.
- One sub-module: instr_word_fifo (synchronous FIFO, DEPTH×32, full/empty, clear).

## Test plan
- tipo00 op00 Inm1 rd3 rn2 imm5 → out_word 0x09900005, out_addr 0 next cycle.
- tipo00 op01 Inm0 rd1 rn2 rm3 → 0x10918000; tipo10 op11 imm 0x7FFFFFC → 0xB7FFFFFC, Inm bit 0.
- tipo00 Inm1 imm 0x0080000 → err_pulse, err_code 3, no word; imm 0x7FFFFFF → [18:0]=0x7FFFF accepted.
- out_ready held 0, push 5 words with DEPTH=4 → in_ready drops after 4th; release → words in order, addresses 0..3, 5th accepted.
- ADDR_W=2, emit 5 words → out_addr 0,1,2,3,0.
- tipo11 with macro → HALT, in_ready 0; clear → in_ready 1, out_addr 0; without macro → in_ready stays 1. Assert rst mid-stream → all outputs to reset values immediately.
